// File: rtl/tone_seq_if.sv
// Note command handshake and tone-generator drive bundle for tone_sequencer.
// master = command source / tone generator side, slave = the sequencer.
interface tone_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_period;
    logic [15:0] cmd_duration_ms;
    logic [3:0]  cmd_volume;
    logic        abort;
    logic        new_period;
    logic [31:0] clks_per_period;
    logic [3:0]  volume;
    logic        busy;
    logic        note_done;

    modport master (
        output cmd_valid, cmd_period, cmd_duration_ms, cmd_volume, abort,
        input  cmd_ready, new_period, clks_per_period, volume, busy, note_done
    );
    modport slave (
        input  cmd_valid, cmd_period, cmd_duration_ms, cmd_volume, abort,
        output cmd_ready, new_period, clks_per_period, volume, busy, note_done
    );
endinterface

// File: rtl/tone_sequencer.sv
// Note-level controller for the PWM tone generator: one note per command,
// linear attack/release envelope, then a silent gap before note_done.
module tone_sequencer #(
    parameter int unsigned CLKS_PER_MS   = 100000,
    parameter int unsigned ENV_STEP_CLKS = 500000,
    parameter int unsigned GAP_MS        = 10
) (
    input  logic       clk,
    input  logic       resetn,
    tone_seq_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_ATTACK, S_SUSTAIN, S_RELEASE, S_GAP} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pre, r_step, r_cpp;
    logic [15:0] r_ms, r_dur, w_ms_inc;
    logic [3:0]  r_tgt, r_vol;
    logic        r_np, r_done;
    logic        w_tick, w_step, w_expire, w_gap_done, w_enter;
    logic        w_accept, w_vol_inc, w_vol_dec, w_done;

    assign w_tick     = (r_pre == CLKS_PER_MS - 1);
    assign w_step     = (r_step == ENV_STEP_CLKS - 1);
    assign w_ms_inc   = r_ms + 16'd1;
    assign w_expire   = w_tick && (w_ms_inc == r_dur);
    assign w_gap_done = (GAP_MS == 0) || (w_tick && (32'(w_ms_inc) == GAP_MS));
    assign w_enter    = (w_state_nxt != r_state);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_vol_inc   = 1'b0;
        w_vol_dec   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_accept = 1'b1;
                    if (bus.cmd_duration_ms != 16'd0) w_state_nxt = S_ATTACK;
                    else                              w_done      = 1'b1;
                end
            end
            S_ATTACK: begin
                // abort outranks ms expiry, which outranks reaching the target
                if (bus.abort || w_expire) w_state_nxt = S_RELEASE;
                else if (r_vol >= r_tgt)   w_state_nxt = S_SUSTAIN;
                else if (w_step)           w_vol_inc   = 1'b1;
            end
            S_SUSTAIN: begin
                if (bus.abort || w_expire) w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (r_vol == 4'd0) w_state_nxt = S_GAP;
                else if (w_step)   w_vol_dec   = 1'b1;
            end
            S_GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // ms prescaler and elapsed counter restart at ATTACK and GAP entry; the
    // count carries across ATTACK->SUSTAIN so duration covers both.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pre <= '0;
            r_ms  <= '0;
        end else if ((w_enter && (w_state_nxt == S_ATTACK || w_state_nxt == S_GAP)) ||
                     r_state == S_IDLE || r_state == S_RELEASE) begin
            r_pre <= '0;
            r_ms  <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
            r_ms  <= w_ms_inc;
        end else begin
            r_pre <= r_pre + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                             r_step <= '0;
        else if (w_enter || !(r_state inside {S_ATTACK, S_RELEASE})) r_step <= '0;
        else if (w_step)                                         r_step <= '0;
        else                                                     r_step <= r_step + 32'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dur  <= '0;
            r_tgt  <= '0;
            r_vol  <= '0;
            r_cpp  <= '0;
            r_np   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_np   <= w_accept && (bus.cmd_duration_ms != 16'd0);
            r_done <= w_done;
            if (w_accept) begin
                r_dur <= bus.cmd_duration_ms;
                r_cpp <= bus.cmd_period;
                // a rest plays silently with normal timing
                r_tgt <= (bus.cmd_period == 32'd0) ? 4'd0 : bus.cmd_volume;
                r_vol <= 4'd0;
            end else if (w_vol_inc && r_vol != 4'hF) begin
                r_vol <= r_vol + 4'd1;
            end else if (w_vol_dec && r_vol != 4'h0) begin
                r_vol <= r_vol - 4'd1;
            end
        end
    end

    assign bus.cmd_ready       = (r_state == S_IDLE);
    assign bus.busy            = (r_state != S_IDLE);
    assign bus.new_period      = r_np;
    assign bus.clks_per_period = r_cpp;
    assign bus.volume          = r_vol;
    assign bus.note_done       = r_done;
endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with small timing parameters; offsets k
// count clock edges after the accepting edge, sampled on the falling edge.
module tb_tone_sequencer;
    localparam int CPM = 10;
    localparam int ESC = 4;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    tone_seq_if bus();

    tone_sequencer #(.CLKS_PER_MS(CPM), .ENV_STEP_CLKS(ESC), .GAP_MS(GAP)) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] period;
        logic [15:0] dur;
        logic [3:0]  vol;
        int          abort_at;
        int          done_at;
        int          peak;
        int          ck_k [4];
        int          ck_v [4];
    } vec_t;

    vec_t vecs [6];
    logic [3:0] vols [150];

    initial begin
        int done_at, np_cnt, peak;

        vecs[0] = '{1000, 5, 3, -1, 83, 3, '{4, 12, 54, 62}, '{1, 3, 2, 0}};
        vecs[1] = '{2000, 1, 15, -1, 39, 2, '{8, 10, 14, 18}, '{2, 2, 1, 0}};
        vecs[2] = '{500, 8, 3, 20, 54, 3, '{24, 25, 29, 33}, '{3, 2, 1, 0}};
        vecs[3] = '{0, 3, 9, -1, 51, 0, '{4, 15, 29, 40}, '{0, 0, 0, 0}};
        vecs[4] = '{700, 2, 0, -1, 41, 0, '{1, 10, 19, 25}, '{0, 0, 0, 0}};
        vecs[5] = '{1000, 5, 3, 55, 83, 3, '{53, 54, 58, 62}, '{3, 2, 1, 0}};

        bus.cmd_valid = 0; bus.cmd_period = 0; bus.cmd_duration_ms = 0;
        bus.cmd_volume = 0; bus.abort = 0;

        // reset state
        #12;
        chk("rst_ready", 32'(bus.cmd_ready), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_volume", 32'(bus.volume), 0);
        chk("rst_cpp", bus.clks_per_period, 0);
        chk("rst_np", 32'(bus.new_period), 0);
        chk("rst_done", 32'(bus.note_done), 0);
        @(negedge clk); resetn = 1;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.cmd_period = vecs[i].period; bus.cmd_duration_ms = vecs[i].dur;
            bus.cmd_volume = vecs[i].vol; bus.cmd_valid = 1;
            chk($sformatf("v%0d_ready", i), 32'(bus.cmd_ready), 1);
            @(posedge clk); #1 bus.cmd_valid = 0;
            done_at = -1; np_cnt = 0; peak = 0;
            for (int k = 0; k < 150; k++) begin
                @(negedge clk);
                vols[k] = bus.volume;
                if (bus.new_period) np_cnt++;
                if (k == 0) chk($sformatf("v%0d_cpp", i), bus.clks_per_period, vecs[i].period);
                if (int'(bus.volume) > peak) peak = int'(bus.volume);
                bus.abort = (k == vecs[i].abort_at);
                if (bus.note_done) begin done_at = k; break; end
            end
            bus.abort = 0;
            chk($sformatf("v%0d_done_at", i), done_at, vecs[i].done_at);
            chk($sformatf("v%0d_peak", i), peak, vecs[i].peak);
            chk($sformatf("v%0d_np_cnt", i), np_cnt, 1);
            for (int c = 0; c < 4; c++)
                if (vecs[i].ck_k[c] <= done_at)
                    chk($sformatf("v%0d_vol@%0d", i, vecs[i].ck_k[c]), 32'(vols[vecs[i].ck_k[c]]), vecs[i].ck_v[c]);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 32'(bus.note_done), 0);
        end

        // zero-duration command completes immediately
        @(negedge clk);
        bus.cmd_period = 1234; bus.cmd_duration_ms = 0; bus.cmd_volume = 5; bus.cmd_valid = 1;
        @(posedge clk); #1 bus.cmd_valid = 0;
        @(negedge clk);
        chk("dur0_done", 32'(bus.note_done), 1);
        chk("dur0_np", 32'(bus.new_period), 0);
        chk("dur0_ready", 32'(bus.cmd_ready), 1);
        chk("dur0_busy", 32'(bus.busy), 0);
        @(negedge clk);
        chk("dur0_done_pulse", 32'(bus.note_done), 0);

        // abort in IDLE is ignored; same-cycle command still accepted
        bus.cmd_period = 300; bus.cmd_duration_ms = 1; bus.cmd_volume = 2;
        bus.cmd_valid = 1; bus.abort = 1;
        @(posedge clk); #1 bus.cmd_valid = 0; bus.abort = 0;
        @(negedge clk);
        chk("idle_abort_np", 32'(bus.new_period), 1);
        chk("idle_abort_busy", 32'(bus.busy), 1);
        chk("idle_abort_cpp", bus.clks_per_period, 300);
        done_at = -1;
        for (int k = 1; k < 150; k++) begin
            @(negedge clk);
            if (k == 8) chk("idle_abort_vol8", 32'(bus.volume), 2);
            if (bus.note_done) begin done_at = k; break; end
        end
        chk("idle_abort_done_at", done_at, 39);

        // async reset mid-SUSTAIN
        @(negedge clk);
        bus.cmd_period = 1000; bus.cmd_duration_ms = 5; bus.cmd_volume = 3; bus.cmd_valid = 1;
        @(posedge clk); #1 bus.cmd_valid = 0;
        repeat (21) @(negedge clk);
        chk("mid_sustain_vol", 32'(bus.volume), 3);
        #2 resetn = 0;
        #1;
        chk("arst_volume", 32'(bus.volume), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_ready", 32'(bus.cmd_ready), 1);
        chk("arst_cpp", bus.clks_per_period, 0);
        chk("arst_np", 32'(bus.new_period), 0);
        @(negedge clk); resetn = 1;

        // valid held high while busy: next accept only after note_done
        @(negedge clk);
        bus.cmd_period = 2000; bus.cmd_duration_ms = 1; bus.cmd_volume = 15; bus.cmd_valid = 1;
        @(posedge clk); #1;
        done_at = -1; np_cnt = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (k >= 1 && done_at < 0 && bus.new_period) np_cnt++;
            if (done_at >= 0) begin
                chk("held_np_after_done", 32'(bus.new_period), 1);
                break;
            end
            if (bus.note_done) done_at = k;
        end
        bus.cmd_valid = 0;
        chk("held_done_at", done_at, 39);
        chk("held_np_while_busy", np_cnt, 0);
        done_at = -1;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (bus.note_done) begin done_at = k; break; end
        end
        chk("held_second_done", 32'(done_at >= 0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
